output_port_bank: RTL

Parametrised memory-mapped output port bank driven by the processor data bus; successor to the fixed 16-port output block.
- Decodes a configurable address window.
- Supports write, set, clear and toggle operations per port.
- Registered readback of port and status registers.
- Per-port update strobe plus pending/ack handshake toward downstream consumers, with sticky overrun detection.

---
 rtl/output_port_pkg.sv | 30 +++
 rtl/output_port_channel.sv | 77 +++++++
 rtl/output_port_bank.sv | 118 +++++++++++
 3 files changed

// File: rtl/output_port_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_port_pkg : op encodings, default map, configuration check     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package output_port_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_SET   = 2'b01,
        OP_CLR   = 2'b10,
        OP_TGL   = 2'b11
    } op_e;

    localparam logic [7:0] DEFAULT_BASE_ADDR   = 8'hE0;
    localparam logic [7:0] DEFAULT_STATUS_ADDR = 8'hF0;

    // The port window must fit in the address space, and the status register
    // must not alias any port.
    function automatic bit cfg_ok(input int num_ports, input int addr_w,
                                  input int base, input int status);
        bit ok;
        ok = (num_ports >= 1) && (addr_w >= 1) && (addr_w <= 30);
        ok = ok && ((base + num_ports) <= (1 << addr_w));
        ok = ok && ((status < base) || (status >= base + num_ports));
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/output_port_channel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_port_channel : one port register, op ALU, strobe/pending/ovr  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module output_port_channel
    import output_port_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hit_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ack_i,
    input  logic              ovr_clr_i,
    output logic [DATA_W-1:0] value_o,
    output logic              strobe_o,
    output logic              pending_o,
    output logic              overrun_o
);

    logic [DATA_W-1:0] value_q, value_d;
    logic              strobe_q;
    logic              pending_q, pending_d;
    logic              overrun_q, overrun_d;
    logic              w_ovr_set;

    always_comb begin
        value_d = value_q;
        if (hit_i) begin
            case (op_i)
                OP_WRITE: value_d = data_i;
                OP_SET:   value_d = value_q | data_i;
                OP_CLR:   value_d = value_q & ~data_i;
                OP_TGL:   value_d = value_q ^ data_i;
                default:  value_d = value_q;
            endcase
        end
    end

    // An ack arriving with the hit consumes the previous update, so no overrun.
    assign w_ovr_set = hit_i & pending_q & ~ack_i;

    always_comb begin
        pending_d = pending_q;
        if (hit_i) begin
            pending_d = 1'b1;
        end else if (ack_i) begin
            pending_d = 1'b0;
        end
    end

    assign overrun_d = w_ovr_set | (overrun_q & ~ovr_clr_i);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value_q   <= '0;
            strobe_q  <= 1'b0;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            strobe_q  <= hit_i;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign value_o   = value_q;
    assign strobe_o  = strobe_q;
    assign pending_o = pending_q;
    assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: rtl/output_port_bank.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | output_port_bank : address decode, channels, status clear, readback  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module output_port_bank
    import output_port_pkg::*;
#(
    parameter int                NUM_PORTS   = 16,
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(DEFAULT_BASE_ADDR),
    parameter logic [ADDR_W-1:0] STATUS_ADDR = ADDR_W'(DEFAULT_STATUS_ADDR)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_en,
    input  logic                          read_en,
    input  logic [1:0]                    op,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             data_in,
    output logic [DATA_W-1:0]             read_data,
    output logic                          read_valid,
    output logic [NUM_PORTS*DATA_W-1:0]   port_out,
    output logic [NUM_PORTS-1:0]          port_strobe,
    output logic [NUM_PORTS-1:0]          port_pending,
    input  logic [NUM_PORTS-1:0]          port_ack,
    output logic [NUM_PORTS-1:0]          overrun
);

    // Only the overrun bits that fit in one bus word are visible/clearable.
    localparam int              c_stat_w = (NUM_PORTS < DATA_W) ? NUM_PORTS : DATA_W;
    localparam logic [ADDR_W:0] c_num    = (ADDR_W+1)'(NUM_PORTS);

    generate
        if (!cfg_ok(NUM_PORTS, ADDR_W, int'(BASE_ADDR), int'(STATUS_ADDR))) begin : g_cfg_err
            $error("output_port_bank: invalid port window / status address");
        end
    endgenerate

    logic [ADDR_W-1:0]    w_offset;
    logic                 w_in_win;
    logic                 w_stat_clr;
    logic [DATA_W-1:0]    w_port [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_ovr;
    logic [DATA_W-1:0]    w_rd_data;
    logic [DATA_W-1:0]    read_data_q;
    logic                 read_valid_q;

    assign w_offset   = address - BASE_ADDR;
    assign w_in_win   = (address >= BASE_ADDR) && ({1'b0, w_offset} < c_num);
    assign w_stat_clr = write_en && (address == STATUS_ADDR) && (op == OP_WRITE);

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_chan
            logic w_hit;
            logic w_clr;

            assign w_hit = write_en && w_in_win && (w_offset == ADDR_W'(i));

            if (i < DATA_W) begin : g_clr
                assign w_clr = w_stat_clr & data_in[i];
            end else begin : g_noclr
                assign w_clr = 1'b0;
            end

            output_port_channel #(
                .DATA_W (DATA_W)
            ) u_chan (
                .clk       (clk),
                .reset     (reset),
                .hit_i     (w_hit),
                .op_i      (op),
                .data_i    (data_in),
                .ack_i     (port_ack[i]),
                .ovr_clr_i (w_clr),
                .value_o   (w_port[i]),
                .strobe_o  (port_strobe[i]),
                .pending_o (port_pending[i]),
                .overrun_o (w_ovr[i])
            );

            assign port_out[i*DATA_W +: DATA_W] = w_port[i];
        end
    endgenerate

    // Readback samples pre-edge values, so a same-cycle write is not visible.
    always_comb begin
        w_rd_data = '0;
        if (w_in_win) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_offset == ADDR_W'(i)) begin
                    w_rd_data = w_port[i];
                end
            end
        end else if (address == STATUS_ADDR) begin
            w_rd_data[c_stat_w-1:0] = w_ovr[c_stat_w-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_data_q  <= '0;
            read_valid_q <= 1'b0;
        end else begin
            read_valid_q <= read_en;
            if (read_en) begin
                read_data_q <= w_rd_data;
            end
        end
    end

    assign read_data  = read_data_q;
    assign read_valid = read_valid_q;
    assign overrun    = w_ovr;

endmodule
`default_nettype wire
